wb_write_queue: RTL and testbench
=================================

# wb_write_queue

Parametrised write-back stage for the IITB RISC pipeline. It accepts register-file write requests from the pipeline, buffers them in a DEPTH-entry in-order queue, and drains them to the register file one per cycle under an `rf_ready` handshake. This lets a busy register-file write port stall writes without stalling the pipeline. A newest-first lookup on pending entries supplies forwarding data to the decode and read stage.

## Interface
- DATA_W, 16, register data width
- ADDR_W, 3, register address width (8 GPRs, R7 = PC)
- DEPTH, 4, queue entries; power of two, ≥ 2
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  pipeline offers a write-back packet
- in_we  in  1  packet actually writes a register; 0 = no-op packet
- in_addr  in  ADDR_W  destination register
- in_data  in  DATA_W  result value
- in_ready  out  1  queue can accept a packet this cycle
- wr_en  out  1  head entry presented to register file
- wr_addr  out  ADDR_W  head entry address
- wr_data  out  DATA_W  head entry data
- rf_ready  in  1  register file accepts the presented write this cycle
- fwd_addr  in  ADDR_W  register being read by decode
- fwd_hit  out  1  a pending entry targets fwd_addr
- fwd_data  out  DATA_W  data of the newest matching pending entry
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Accept: the cycle is an accept when `in_valid && in_ready`.
  - With `in_we=1`, the entry is pushed at the tail.
  - With `in_we=0`, the packet is consumed and discarded; no state changes.
- in_ready = (count < DEPTH). It is a function of registered state only, with no combinational path from `rf_ready` or `in_valid`.
- Drain: wr_en = (count != 0). wr_addr and wr_data always reflect the head entry. A pop occurs when `wr_en && rf_ready`.
- Simultaneous push and pop: count is unchanged. Head and tail pointers both advance modulo DEPTH.
- Ordering: writes leave in acceptance order. Two pending writes to the same register are both performed; there is no coalescing.
- Forwarding (combinational):
  - fwd_hit = 1 if any occupied entry has address == fwd_addr.
  - fwd_data is taken from the most recently pushed matching entry.
  - The head entry counts as a hit in the cycle it is popped.
  - Incoming in_* packets are not searched.
  - When fwd_hit = 0, fwd_data = 0.
- Pointers are ADDR-agnostic, $clog2(DEPTH) bits, and wrap naturally.
- Count saturates by construction: there is no push when full and no pop when empty.

## Timing
- Reset (asynchronous assert, synchronous release on clk) clears:
  - count = 0, pointers = 0, all entry storage = 0.
  - Outputs: wr_en = 0, wr_addr = 0, wr_data = 0, fwd_hit = 0, fwd_data = 0, in_ready = 1.
- Reset mid-operation: all pending writes are discarded. No write is presented in any cycle while resetn = 0.
- Latency: a packet accepted at edge N appears on wr_* (wr_en = 1) in the cycle after edge N when the queue was empty. It becomes visible to forwarding in that same cycle.
- Throughput: one accept and one drain per cycle sustained. Full-queue push with a same-cycle pop is refused, because in_ready = 0 when count = DEPTH.
- rf_ready low holds wr_en, wr_addr and wr_data stable until a pop.
- Empty queue: rf_ready is ignored and wr_en = 0.

## Test plan
- Single write with rf_ready=1: accept {addr=3, data=16'hABCD} at edge 1 → wr_en=1, wr_addr=3, wr_data=16'hABCD in cycle 2 → count=0 after edge 2.
- Fill with rf_ready=0: push addrs 1,2,3,4 (data 16'h0011..16'h0044) → in_ready=0 and count=4 → with rf_ready=1, drains 1,2,3,4 in order over 4 cycles → in_ready returns to 1 after the first pop.
- Forwarding priority: push {5,16'h1111} then {5,16'h2222}, rf_ready=0, fwd_addr=5 → fwd_hit=1, fwd_data=16'h2222. With fwd_addr=6 → fwd_hit=0, fwd_data=0.
- Simultaneous push/pop at count=2 → count remains 2, order preserved. Also run pointer wrap over ≥3×DEPTH continuous transfers with no loss or duplication.
- No-op packet: in_valid=1, in_we=0 → accepted, count unchanged, wr_en unaffected.
- Reset mid-drain: count=3, resetn pulled low mid-cycle → wr_en=0 and count=0 immediately. After release, no stale entries are written and in_ready=1.

Source files
------------

// File: rtl/wb_write_queue.sv
// In-order write-back queue between pipeline and register-file write port.
// Ports: in_* push side, wr_*/rf_ready drain side, fwd_* lookup, count.
module wb_write_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  input  logic                     in_we,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  input  logic                     rf_ready,
  input  logic [ADDR_W-1:0]        fwd_addr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic push;
  logic pop;

  // in_ready depends on registered occupancy only.
  assign in_ready = (count_q < FULL);
  assign wr_en    = (count_q != '0);
  assign wr_addr  = addr_q[head_q];
  assign wr_data  = data_q[head_q];
  assign count    = count_q;

  // No-op packets are accepted but never stored.
  assign push = in_valid && in_ready && in_we;
  assign pop  = wr_en && rf_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        addr_q[tail_q] <= in_addr;
        data_q[tail_q] <= in_data;
      end
    end
  end

  // Walk oldest to newest so the newest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: vector table plus
// wrap/backpressure stream and mid-drain reset sequences.
module tb_wb_write_queue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_we;
  logic [2:0]  in_addr;
  logic [15:0] in_data;
  logic        in_ready;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rf_ready;
  logic [2:0]  fwd_addr;
  logic        fwd_hit;
  logic [15:0] fwd_data;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  wb_write_queue #(.DATA_W(16), .ADDR_W(3), .DEPTH(4)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_we    (in_we),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rf_ready (rf_ready),
    .fwd_addr (fwd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        iwe;
    logic [2:0]  ia;
    logic [15:0] id;
    logic        rf;
    logic [2:0]  fa;
    logic        e_ir;
    logic        e_we;
    logic [2:0]  e_wa;
    logic [15:0] e_wd;
    logic        e_hit;
    logic [15:0] e_fd;
    logic [2:0]  e_cnt;
    logic        wchk;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    logic iv, logic iwe, logic [2:0] ia, logic [15:0] id,
    logic rf, logic [2:0] fa,
    logic ir, logic we, logic [2:0] wa, logic [15:0] wd,
    logic hit, logic [15:0] fd, logic [2:0] cnt, logic wchk);
    vec_t v;
    v.iv = iv; v.iwe = iwe; v.ia = ia; v.id = id;
    v.rf = rf; v.fa = fa;
    v.e_ir = ir; v.e_we = we; v.e_wa = wa; v.e_wd = wd;
    v.e_hit = hit; v.e_fd = fd; v.e_cnt = cnt; v.wchk = wchk;
    return v;
  endfunction

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got %0h want %0h", nm, k, act, exp);
    end
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_we    = 1'b0;
    in_addr  = '0;
    in_data  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [18:0] sb[$];
    logic [18:0] fr;
    int pushed;
    int popped;

    resetn   = 1'b0;
    rf_ready = 1'b0;
    fwd_addr = '0;
    idle_in();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    //        iv iwe ia  id        rf fa | ir we wa wd       hit fd       cnt wchk
    vt.push_back(mk(0,0,0,16'h0000, 0,0, 1,0,0,16'h0000, 0,16'h0000, 0,1));
    vt.push_back(mk(1,1,3,16'hABCD, 1,3, 1,0,0,16'h0000, 0,16'h0000, 0,1));
    vt.push_back(mk(0,0,0,16'h0000, 1,3, 1,1,3,16'hABCD, 1,16'hABCD, 1,1));
    vt.push_back(mk(0,0,0,16'h0000, 0,3, 1,0,0,16'h0000, 0,16'h0000, 0,0));
    vt.push_back(mk(1,1,1,16'h0011, 0,1, 1,0,0,16'h0000, 0,16'h0000, 0,0));
    vt.push_back(mk(1,1,2,16'h0022, 0,1, 1,1,1,16'h0011, 1,16'h0011, 1,1));
    vt.push_back(mk(1,1,3,16'h0033, 0,2, 1,1,1,16'h0011, 1,16'h0022, 2,1));
    vt.push_back(mk(1,1,4,16'h0044, 0,4, 1,1,1,16'h0011, 0,16'h0000, 3,1));
    vt.push_back(mk(1,1,5,16'h0055, 1,4, 0,1,1,16'h0011, 1,16'h0044, 4,1));
    vt.push_back(mk(0,0,0,16'h0000, 1,5, 1,1,2,16'h0022, 0,16'h0000, 3,1));
    vt.push_back(mk(0,0,0,16'h0000, 1,3, 1,1,3,16'h0033, 1,16'h0033, 2,1));
    vt.push_back(mk(0,0,0,16'h0000, 1,0, 1,1,4,16'h0044, 0,16'h0000, 1,1));
    vt.push_back(mk(0,0,0,16'h0000, 0,0, 1,0,0,16'h0000, 0,16'h0000, 0,0));
    vt.push_back(mk(1,1,5,16'h1111, 0,5, 1,0,0,16'h0000, 0,16'h0000, 0,0));
    vt.push_back(mk(1,1,5,16'h2222, 0,5, 1,1,5,16'h1111, 1,16'h1111, 1,1));
    vt.push_back(mk(0,0,0,16'h0000, 0,5, 1,1,5,16'h1111, 1,16'h2222, 2,1));
    vt.push_back(mk(0,0,0,16'h0000, 0,6, 1,1,5,16'h1111, 0,16'h0000, 2,1));
    vt.push_back(mk(1,1,6,16'h0066, 1,6, 1,1,5,16'h1111, 0,16'h0000, 2,1));
    vt.push_back(mk(1,1,7,16'h0077, 1,5, 1,1,5,16'h2222, 1,16'h2222, 2,1));
    vt.push_back(mk(1,0,1,16'h0999, 0,1, 1,1,6,16'h0066, 0,16'h0000, 2,1));
    vt.push_back(mk(0,0,0,16'h0000, 0,1, 1,1,6,16'h0066, 0,16'h0000, 2,1));
    vt.push_back(mk(0,0,0,16'h0000, 1,7, 1,1,6,16'h0066, 1,16'h0077, 2,1));
    vt.push_back(mk(0,0,0,16'h0000, 1,7, 1,1,7,16'h0077, 1,16'h0077, 1,1));
    vt.push_back(mk(0,0,0,16'h0000, 0,7, 1,0,0,16'h0000, 0,16'h0000, 0,0));

    foreach (vt[k]) begin
      in_valid = vt[k].iv;
      in_we    = vt[k].iwe;
      in_addr  = vt[k].ia;
      in_data  = vt[k].id;
      rf_ready = vt[k].rf;
      fwd_addr = vt[k].fa;
      #1;
      chk("in_ready", k, 32'(in_ready), 32'(vt[k].e_ir));
      chk("wr_en",    k, 32'(wr_en),    32'(vt[k].e_we));
      if (vt[k].wchk) begin
        chk("wr_addr", k, 32'(wr_addr), 32'(vt[k].e_wa));
        chk("wr_data", k, 32'(wr_data), 32'(vt[k].e_wd));
      end
      chk("fwd_hit",  k, 32'(fwd_hit),  32'(vt[k].e_hit));
      chk("fwd_data", k, 32'(fwd_data), 32'(vt[k].e_fd));
      chk("count",    k, 32'(count),    32'(vt[k].e_cnt));
      @(posedge clk);
      @(negedge clk);
    end

    // Continuous stream with intermittent backpressure, wraps pointers 4x.
    pushed = 0;
    popped = 0;
    for (int c = 0; c < 200 && popped < 16; c++) begin
      in_valid = (pushed < 16);
      in_we    = 1'b1;
      in_addr  = 3'(pushed);
      in_data  = 16'hA000 + 16'(pushed);
      rf_ready = ((c % 3) != 2);
      fwd_addr = '0;
      #1;
      chk("wrap_count", c, 32'(count), 32'(sb.size()));
      if (wr_en && rf_ready) begin
        chk("wrap_nonempty", c, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          fr = sb.pop_front();
          chk("wrap_data", c, {13'd0, wr_addr, wr_data}, {13'd0, fr});
          popped++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back({in_addr, in_data});
        pushed++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    idle_in();
    rf_ready = 1'b0;
    #1;
    chk("wrap_pushed", 0, 32'(pushed), 32'd16);
    chk("wrap_popped", 0, 32'(popped), 32'd16);
    chk("wrap_empty",  0, 32'(count),  32'd0);
    @(negedge clk);

    // Reset in the middle of a drain.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_we    = 1'b1;
      in_addr  = 3'(k + 1);
      in_data  = 16'h0100 + 16'(k);
      @(posedge clk);
      @(negedge clk);
    end
    idle_in();
    fwd_addr = 3'd2;
    #1;
    chk("rst_pre_count", 0, 32'(count),   32'd3);
    chk("rst_pre_wr_en", 0, 32'(wr_en),   32'd1);
    chk("rst_pre_hit",   0, 32'(fwd_hit), 32'd1);
    #2;
    rf_ready = 1'b1;
    resetn   = 1'b0;
    #1;
    chk("rst_wr_en",    0, 32'(wr_en),    32'd0);
    chk("rst_count",    0, 32'(count),    32'd0);
    chk("rst_in_ready", 0, 32'(in_ready), 32'd1);
    chk("rst_hit",      0, 32'(fwd_hit),  32'd0);
    chk("rst_wr_addr",  0, 32'(wr_addr),  32'd0);
    @(negedge clk);
    chk("rst_hold_wr_en", 0, 32'(wr_en), 32'd0);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("post_wr_en",    k, 32'(wr_en),    32'd0);
      chk("post_count",    k, 32'(count),    32'd0);
      chk("post_in_ready", k, 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
